mac_pe_vec: RTL and testbench
=============================

Name: mac_pe_vec

Overview:
Parametrised successor to the single-lane MAC processing element. It computes LANES dot products in parallel against one streamed activation vector. Each lane holds its own local weight RAM. Arithmetic is signed fixed-point throughout, with no float conversion. Results are rounded, shifted and saturated, then returned through a valid/ready output handshake. The block sits between the activation stream and the result collector in the accelerator datapath.

Parameters:
DATA_W, 16, signed width of activations and weights
LANES, 4, number of parallel MAC lanes (>=1)
L_RAM_SIZE, 6, log2 of weight RAM depth per lane
ACC_W, 40, signed accumulator width; must be >= 2*DATA_W+L_RAM_SIZE (elaboration error otherwise)
FRAC_W, 8, right-shift applied to the accumulator on output (0 allowed)
OUT_W, 32, signed width of each lane result

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous, active-high reset
cfg_len  in  L_RAM_SIZE+1  vector length, sampled on start
cfg_accum  in  1  sampled on start; 1 = keep accumulators from previous pass
start  in  1  single-cycle pass request
busy  out  1  high from accepted start until output handshake completes
err  out  1  one-cycle pulse on rejected start
we  in  1  weight write strobe
waddr  in  L_RAM_SIZE  weight address
wlane  in  max(1,clog2(LANES))  target lane
wdata  in  DATA_W  weight value
s_valid  in  1  activation valid
s_ready  out  1  activation ready
s_ain  in  DATA_W  activation, broadcast to all lanes
m_valid  out  1  results valid
m_ready  in  1  results consumed
m_dout  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
m_sat  out  LANES  per-lane saturation flag

Behaviour:
- Reset values:
  - busy=0, err=0, s_ready=0, m_valid=0, m_dout=0, m_sat=0.
  - State IDLE, counters 0, accumulators 0.
  - RAM contents are not reset and are retained.
- FSM states IDLE, RUN, DRAIN, OUT.
- IDLE, start accepted (1 <= cfg_len <= 2**L_RAM_SIZE):
  - latch len; clear accumulators unless cfg_accum=1; elem counter=0; go to RUN.
- IDLE, start rejected (cfg_len=0 or cfg_len > depth): err pulses on the next cycle; state stays IDLE.
- start outside IDLE: ignored, no err.
- Weight writes take effect only in IDLE: RAM[wlane][waddr] <= wdata. we outside IDLE is ignored.
- RUN:
  - s_ready=1 while elem counter < len.
  - Each handshake reads RAM[*][counter] and increments the counter.
  - When the final element is accepted, s_ready drops on the following cycle and state goes to DRAIN.
- Pipeline per handshake at edge E:
  - E+1: weight read out, activation registered.
  - E+2: product registered (full 2*DATA_W, signed).
  - E+3: sign-extended add into the accumulator.
  - Throughput is one element per cycle; bubbles from s_valid=0 are allowed.
- DRAIN: waits until the last accumulate lands, then computes output at E_last+4.
  - m_valid rises on edge E_last+4; state goes to OUT.
- Output arithmetic per lane:
  - r = (acc + (FRAC_W>0 ? 2**(FRAC_W-1) : 0)) >>> FRAC_W (arithmetic shift).
  - Saturate r to the signed OUT_W range; m_sat[i]=1 if clipped.
- OUT:
  - m_dout and m_sat are held stable while m_valid=1 and m_ready=0.
  - On m_valid&m_ready: m_valid=0, busy=0 on the next edge; go to IDLE.
  - Accumulators are retained, so a following cfg_accum=1 pass continues the sum.
- busy is asserted the edge after start is accepted.
- Asynchronous reset mid-pass: immediately returns to reset values. Any in-flight elements are discarded.

Decomposition:
- Package mac_pe_vec_pkg: FSM state enum; constant function for lane-select width; rounding-constant function.
- One sub-module mac_vec_lane: weight RAM (block RAM, registered read), multiplier stage, accumulator, and round/saturate logic. Instantiated LANES times.
- The top level holds the FSM, counters and handshakes.

Test Plan:
- Basic pass:
  - Setup: LANES=4, FRAC_W=0. Weights lane i = i+1 at addresses 0..3. cfg_len=4. Stream ain=1,2,3,4 with s_valid held high.
  - Expect: m_dout lanes = 10,20,30,40. m_valid rises exactly 4 cycles after the 4th handshake.
- Backpressure and bubbles:
  - Stimulus: same as the basic pass, with s_valid toggling 1/0 and m_ready held low for 5 cycles.
  - Expect: identical results; m_dout stable during the stall; busy drops one cycle after the m_ready handshake.
- Accumulate mode:
  - Stimulus: repeat the basic pass with cfg_accum=1.
  - Expect: 20,40,60,80. A third pass with cfg_accum=0 returns 10,20,30,40.
- Rounding and saturation (FRAC_W=8, OUT_W=16):
  - Stimulus: weight 0x7FFF and ain 0x7FFF over len 64.
  - Expect: output 0x7FFF, m_sat=1. A weight/ain product of 384 gives output 2 (round half up).
- Rejects:
  - Stimulus: start with cfg_len=0 and with cfg_len=65.
  - Expect: err pulse, busy stays 0.
  - Stimulus: we during RUN.
  - Expect: RAM unchanged, verified by a subsequent pass.
- Mid-pass reset:
  - Stimulus: assert areset after 2 of 4 elements.
  - Expect: all outputs 0 immediately. A fresh pass returns the correct result from the retained weights.

Source files
------------

// File: rtl/mac_pe_vec_pkg.sv
// mac_pe_vec_pkg
//   Shared types and helpers for the vector MAC processing element.
//   - state_e     : control FSM states of mac_pe_vec
//   - lane_sel_w  : width of the lane-select field (at least 1 bit)
//   - round_const : half-LSB rounding constant for a given right shift
package mac_pe_vec_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_e;

  function automatic int unsigned lane_sel_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic logic [63:0] round_const(input int unsigned frac_w);
    return (frac_w > 0) ? (64'd1 << (frac_w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/mac_vec_lane.sv
// mac_vec_lane
//   One MAC lane: local weight RAM with registered read, signed multiply,
//   accumulate, and round/shift/saturate of the accumulator on request.
//   Ports:
//     clk_i, rst_i        clock, asynchronous active-high reset
//     we_i/waddr_i/wdata_i weight RAM write port (gated by the caller)
//     raddr_i, ain_i      element address and activation, captured every cycle
//     acc_clr_i           clear accumulator
//     acc_en_i            add the registered product into the accumulator
//     out_en_i            register rounded/saturated result
//     dout_o, sat_o       lane result and saturation flag
module mac_vec_lane
  import mac_pe_vec_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned L_RAM_SIZE = 6,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned OUT_W      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [L_RAM_SIZE-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [L_RAM_SIZE-1:0] raddr_i,
  input  logic [DATA_W-1:0]     ain_i,
  input  logic                  acc_clr_i,
  input  logic                  acc_en_i,
  input  logic                  out_en_i,
  output logic [OUT_W-1:0]      dout_o,
  output logic                  sat_o
);

  localparam int unsigned DEPTH = 2 ** L_RAM_SIZE;
  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned EXT   = ACC_W - PW;
  localparam int unsigned RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] RC   = RW'(round_const(FRAC_W));
  localparam logic signed [RW-1:0] OMAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = ~OMAX;

  logic        [DATA_W-1:0]     ram_q [DEPTH];
  logic        [L_RAM_SIZE-1:0] raddr_q;
  logic signed [DATA_W-1:0]     w_q;
  logic signed [DATA_W-1:0]     a0_q, a1_q;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic        [OUT_W-1:0]      dout_q, dout_d;
  logic                         sat_q, sat_d;
  logic signed [RW-1:0]         sum_w, shifted_w;

  // Block-RAM style: write port plus registered read, no reset on contents.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      ram_q[waddr_i] <= wdata_i;
    end
    w_q <= ram_q[raddr_q];
  end

  assign prod_d = w_q * a1_q;

  always_comb begin
    acc_d = acc_q;
    if (acc_clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + {{EXT{prod_q[PW-1]}}, prod_q};
    end
  end

  // One extra bit so the rounding add can never wrap.
  assign sum_w     = {acc_q[ACC_W-1], acc_q} + RC;
  assign shifted_w = sum_w >>> FRAC_W;

  always_comb begin
    dout_d = shifted_w[OUT_W-1:0];
    sat_d  = 1'b0;
    if (shifted_w > OMAX) begin
      dout_d = OMAX[OUT_W-1:0];
      sat_d  = 1'b1;
    end else if (shifted_w < OMIN) begin
      dout_d = OMIN[OUT_W-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      raddr_q <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      raddr_q <= raddr_i;
      a0_q    <= ain_i;
      a1_q    <= a0_q;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      if (out_en_i) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign dout_o = dout_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/mac_pe_vec.sv
// mac_pe_vec
//   LANES parallel signed dot products against one streamed activation
//   vector, each lane with its own weight RAM. Results are rounded,
//   shifted by FRAC_W, saturated to OUT_W and returned by valid/ready.
//   Ports:
//     aclk, areset            clock, asynchronous active-high reset
//     cfg_len, cfg_accum      pass length / keep-accumulator flag, taken on start
//     start, busy, err        pass request, pass in progress, rejected-start pulse
//     we, waddr, wlane, wdata weight write (honoured only while idle)
//     s_valid/s_ready/s_ain   activation stream, broadcast to all lanes
//     m_valid/m_ready         result handshake
//     m_dout, m_sat           lane i at [i*OUT_W +: OUT_W], per-lane saturation
module mac_pe_vec
  import mac_pe_vec_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned L_RAM_SIZE = 6,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned OUT_W      = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic [L_RAM_SIZE:0]             cfg_len,
  input  logic                            cfg_accum,
  input  logic                            start,
  output logic                            busy,
  output logic                            err,
  input  logic                            we,
  input  logic [L_RAM_SIZE-1:0]           waddr,
  input  logic [lane_sel_w(LANES)-1:0]    wlane,
  input  logic [DATA_W-1:0]               wdata,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_W-1:0]               s_ain,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [LANES*OUT_W-1:0]          m_dout,
  output logic [LANES-1:0]                m_sat
);

  localparam int unsigned LSW   = lane_sel_w(LANES);
  localparam int unsigned LEN_W = L_RAM_SIZE + 1;
  localparam int unsigned DEPTH = 2 ** L_RAM_SIZE;

  if (ACC_W < 2 * DATA_W + L_RAM_SIZE) begin : g_bad_acc_w
    $error("mac_pe_vec: ACC_W must be >= 2*DATA_W+L_RAM_SIZE");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("mac_pe_vec: LANES must be >= 1");
  end
  if (OUT_W > ACC_W) begin : g_bad_out_w
    $error("mac_pe_vec: OUT_W must not exceed ACC_W");
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [2:0]       v_q, v_d;
  logic             len_ok, hs, acc_clr, out_en, ram_we_ok;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
  assign s_ready   = (state_q == S_RUN) && (cnt_q < len_q);
  assign hs        = s_valid && s_ready;
  assign ram_we_ok = we && (state_q == S_IDLE);

  // v_q tracks each accepted element through read, multiply and accumulate;
  // v_q[2] marks the cycle whose product is added at the next edge.
  assign v_d = {v_q[1:0], hs};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    acc_clr = 1'b0;
    out_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = cfg_len;
            cnt_d   = '0;
            acc_clr = !cfg_accum;
            state_d = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Empty pipeline means the final accumulate has landed.
        if (v_q == '0) begin
          out_en  = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (m_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      v_q     <= v_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign m_valid = (state_q == S_OUT);
  assign err     = err_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_vec_lane #(
      .DATA_W    (DATA_W),
      .L_RAM_SIZE(L_RAM_SIZE),
      .ACC_W     (ACC_W),
      .FRAC_W    (FRAC_W),
      .OUT_W     (OUT_W)
    ) u_lane (
      .clk_i    (aclk),
      .rst_i    (areset),
      .we_i     (ram_we_ok && (wlane == LSW'(i))),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .raddr_i  (cnt_q[L_RAM_SIZE-1:0]),
      .ain_i    (s_ain),
      .acc_clr_i(acc_clr),
      .acc_en_i (v_q[2]),
      .out_en_i (out_en),
      .dout_o   (m_dout[i*OUT_W +: OUT_W]),
      .sat_o    (m_sat[i])
    );
  end

endmodule

// File: tb/tb_mac_pe_vec.sv
module tb_mac_pe_vec;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [6:0]   cfg_len = '0;
  logic         cfg_accum = 1'b0;
  logic         start = 1'b0;
  logic         we = 1'b0;
  logic [5:0]   waddr = '0;
  logic [1:0]   wlane = '0;
  logic [15:0]  wdata = '0;
  logic         s_valid = 1'b0;
  logic [15:0]  s_ain = '0;
  logic         m_ready = 1'b0;

  logic         busy, err, s_ready, m_valid;
  logic [127:0] m_dout;
  logic [3:0]   m_sat;
  logic         busy2, err2, s_ready2, m_valid2;
  logic [63:0]  m_dout2;
  logic [3:0]   m_sat2;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  // reference model state
  longint             w_m [4][64];
  longint             acc_m [4];
  logic signed [15:0] ain_buf [64];

  // results of the most recent pass
  int           r_lat;
  bit           r_to, r_stable, r_busy_ok, r_drop_ok;
  logic [127:0] r_dout;
  logic [3:0]   r_sat;
  logic [63:0]  r_dout2;
  logic [3:0]   r_sat2;

  mac_pe_vec #(.FRAC_W(0)) u_dut (
    .aclk(aclk), .areset(areset), .cfg_len(cfg_len), .cfg_accum(cfg_accum),
    .start(start), .busy(busy), .err(err), .we(we), .waddr(waddr),
    .wlane(wlane), .wdata(wdata), .s_valid(s_valid), .s_ready(s_ready),
    .s_ain(s_ain), .m_valid(m_valid), .m_ready(m_ready), .m_dout(m_dout),
    .m_sat(m_sat)
  );

  mac_pe_vec #(.FRAC_W(8), .OUT_W(16)) u_dut2 (
    .aclk(aclk), .areset(areset), .cfg_len(cfg_len), .cfg_accum(cfg_accum),
    .start(start), .busy(busy2), .err(err2), .we(we), .waddr(waddr),
    .wlane(wlane), .wdata(wdata), .s_valid(s_valid), .s_ready(s_ready2),
    .s_ain(s_ain), .m_valid(m_valid2), .m_ready(m_ready), .m_dout(m_dout2),
    .m_sat(m_sat2)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected lane output: round half up, arithmetic shift, clip to ow bits.
  function automatic longint exp_out(input longint acc, input int frac, input int ow, output bit sat);
    longint r, mx, mn;
    r  = (frac > 0) ? ((acc + (longint'(1) <<< (frac - 1))) >>> frac) : acc;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    sat = 1'b0;
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
    return r;
  endfunction

  task automatic write_w(input int l, input int a, input logic [15:0] d);
    we = 1'b1; wlane = l[1:0]; waddr = a[5:0]; wdata = d;
    @(negedge aclk);
    we = 1'b0;
    w_m[l][a] = longint'($signed(d));
  endtask

  // bub: 0 = s_valid held high, 1 = alternating, 2 = random
  task automatic run_pass(input int len, input bit accum, input int bub, input int stall, input bit we_in_run);
    int i, guard, hs_cyc;
    r_to = 0; r_stable = 1; r_busy_ok = 1; r_lat = -1; hs_cyc = 0;
    cfg_len = len[6:0]; cfg_accum = accum; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    if (we_in_run) begin we = 1'b1; wlane = 2'd0; waddr = 6'd0; wdata = 16'h1234; end
    i = 0; guard = 0;
    while (i < len && guard < 1000) begin
      s_valid = (bub == 0) ? 1'b1 : (bub == 1) ? (guard % 2 == 0) : ($urandom_range(0, 3) != 0);
      s_ain = ain_buf[i];
      if (busy !== 1'b1) r_busy_ok = 0;
      if (s_valid && s_ready) begin hs_cyc = cyc + 1; i++; end
      @(negedge aclk);
      we = 1'b0;
      guard++;
    end
    s_valid = 1'b0;
    if (i < len) r_to = 1;
    guard = 0;
    while (m_valid !== 1'b1 && guard < 100) begin @(negedge aclk); guard++; end
    if (m_valid !== 1'b1) r_to = 1;
    else r_lat = cyc - hs_cyc;
    r_dout = m_dout; r_sat = m_sat; r_dout2 = m_dout2; r_sat2 = m_sat2;
    for (int k = 0; k < stall; k++) begin
      @(negedge aclk);
      if (m_valid !== 1'b1 || m_dout !== r_dout || m_sat !== r_sat) r_stable = 0;
    end
    m_ready = 1'b1;
    @(negedge aclk);
    m_ready = 1'b0;
    r_drop_ok = (busy === 1'b0) && (m_valid === 1'b0) && (busy2 === 1'b0);
    for (int l = 0; l < 4; l++) begin
      if (!accum) acc_m[l] = 0;
      for (int k = 0; k < len; k++) acc_m[l] += w_m[l][k] * longint'(ain_buf[k]);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    total_cnt++;
    if ({busy, err, s_ready, m_valid, m_sat} !== 8'h00 || m_dout !== '0)
      $display("FAIL reset_in: got busy=%b err=%b rdy=%b mv=%b dout=%h sat=%b want all 0", busy, err, s_ready, m_valid, m_dout, m_sat);
    else pass_cnt++;
    areset = 1'b0;
    @(negedge aclk);
    total_cnt++;
    if ({busy, err, s_ready, m_valid} !== 4'h0 || m_dout2 !== '0)
      $display("FAIL reset_out: got busy=%b err=%b rdy=%b mv=%b dout2=%h want all 0", busy, err, s_ready, m_valid, m_dout2);
    else pass_cnt++;
    for (int l = 0; l < 4; l++) acc_m[l] = 0;
  endtask

  task automatic test_basic;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 4; a++) write_w(l, a, 16'(l + 1));
    for (int k = 0; k < 4; k++) ain_buf[k] = 16'(k + 1);
    run_pass(4, 0, 0, 0, 0);
    total_cnt++;
    if (r_to || r_lat != 4) $display("FAIL basic_latency: got %0d (timeout=%0d) want 4", r_lat, r_to);
    else pass_cnt++;
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout[l*32 +: 32] !== 32'(10 * (l + 1)) || r_sat[l] !== 1'b0)
        $display("FAIL basic_lane%0d: got %0d sat=%b want %0d sat=0", l, r_dout[l*32 +: 32], r_sat[l], 10 * (l + 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (!r_busy_ok || !r_drop_ok) $display("FAIL basic_busy: got run_ok=%0d drop_ok=%0d want 1/1", r_busy_ok, r_drop_ok);
    else pass_cnt++;
  endtask

  task automatic test_backpressure;
    run_pass(4, 0, 1, 5, 0);
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout[l*32 +: 32] !== 32'(10 * (l + 1)))
        $display("FAIL bp_lane%0d: got %0d want %0d", l, r_dout[l*32 +: 32], 10 * (l + 1));
      else pass_cnt++;
    end
    total_cnt++;
    if (r_to || r_lat != 4 || !r_stable || !r_drop_ok)
      $display("FAIL bp_timing: got lat=%0d to=%0d stable=%0d drop=%0d want 4/0/1/1", r_lat, r_to, r_stable, r_drop_ok);
    else pass_cnt++;
  endtask

  task automatic test_accum;
    run_pass(4, 1, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout[l*32 +: 32] !== 32'(20 * (l + 1)))
        $display("FAIL accum_lane%0d: got %0d want %0d", l, r_dout[l*32 +: 32], 20 * (l + 1));
      else pass_cnt++;
    end
    run_pass(4, 0, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout[l*32 +: 32] !== 32'(10 * (l + 1)))
        $display("FAIL noaccum_lane%0d: got %0d want %0d", l, r_dout[l*32 +: 32], 10 * (l + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_reject;
    int lens [2] = '{0, 65};
    for (int j = 0; j < 2; j++) begin
      cfg_len = lens[j][6:0]; start = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      total_cnt++;
      if (err !== 1'b1 || busy !== 1'b0)
        $display("FAIL reject_len%0d: got err=%b busy=%b want err=1 busy=0", lens[j], err, busy);
      else pass_cnt++;
      @(negedge aclk);
      total_cnt++;
      if (err !== 1'b0 || busy !== 1'b0)
        $display("FAIL reject_pulse_len%0d: got err=%b busy=%b want 0/0", lens[j], err, busy);
      else pass_cnt++;
    end
    run_pass(4, 0, 0, 0, 1);
    run_pass(4, 0, 0, 0, 0);
    total_cnt++;
    if (r_dout[31:0] !== 32'd10) $display("FAIL we_in_run: got %0d want 10", r_dout[31:0]);
    else pass_cnt++;
  endtask

  task automatic test_midpass_reset;
    cfg_len = 7'd4; cfg_accum = 1'b0; start = 1'b1;
    @(negedge aclk);
    start = 1'b0; s_valid = 1'b1; s_ain = ain_buf[0];
    @(negedge aclk);
    s_ain = ain_buf[1];
    @(negedge aclk);
    s_valid = 1'b0; areset = 1'b1;
    #1;
    total_cnt++;
    if ({busy, err, s_ready, m_valid, m_sat} !== 8'h00 || m_dout !== '0)
      $display("FAIL midreset_out: got busy=%b rdy=%b mv=%b dout=%h want all 0", busy, s_ready, m_valid, m_dout);
    else pass_cnt++;
    @(negedge aclk);
    areset = 1'b0;
    for (int l = 0; l < 4; l++) acc_m[l] = 0;
    @(negedge aclk);
    run_pass(4, 1, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout[l*32 +: 32] !== 32'(10 * (l + 1)))
        $display("FAIL midreset_lane%0d: got %0d want %0d", l, r_dout[l*32 +: 32], 10 * (l + 1));
      else pass_cnt++;
    end
  endtask

  task automatic test_round_sat;
    longint e; bit s;
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 64; a++) write_w(l, a, 16'h7FFF);
    for (int k = 0; k < 64; k++) ain_buf[k] = 16'h7FFF;
    run_pass(64, 0, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      total_cnt++;
      if (r_dout2[l*16 +: 16] !== 16'h7FFF || r_sat2[l] !== 1'b1)
        $display("FAIL sat16_lane%0d: got %h sat=%b want 7fff sat=1", l, r_dout2[l*16 +: 16], r_sat2[l]);
      else pass_cnt++;
      e = exp_out(acc_m[l], 0, 32, s);
      total_cnt++;
      if (longint'($signed(r_dout[l*32 +: 32])) !== e || r_sat[l] !== s)
        $display("FAIL sat32_lane%0d: got %h sat=%b want %h sat=%b", l, r_dout[l*32 +: 32], r_sat[l], e, s);
      else pass_cnt++;
    end
    for (int l = 0; l < 4; l++) write_w(l, 0, 16'(l + 1));
    ain_buf[0] = 16'sd128;
    run_pass(1, 0, 0, 0, 0);
    total_cnt++;
    if (r_dout2[47:32] !== 16'd2 || r_sat2[2] !== 1'b0)
      $display("FAIL round_384: got %0d sat=%b want 2 sat=0", r_dout2[47:32], r_sat2[2]);
    else pass_cnt++;
    ain_buf[0] = -16'sd128;
    run_pass(1, 0, 0, 0, 0);
    for (int l = 0; l < 4; l++) begin
      e = exp_out(acc_m[l], 8, 16, s);
      total_cnt++;
      if (longint'($signed(r_dout2[l*16 +: 16])) !== e || r_sat2[l] !== s)
        $display("FAIL round_neg_lane%0d: got %0d want %0d", l, $signed(r_dout2[l*16 +: 16]), e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    int len, v; bit acc; longint e1, e2; bit s1, s2;
    for (int it = 0; it < 6; it++) begin
      len = (it == 0) ? 64 : $urandom_range(1, 64);
      acc = (it == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      for (int l = 0; l < 4; l++)
        for (int a = 0; a < len; a++) begin
          v = (it % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 1023)) - 512;
          write_w(l, a, v[15:0]);
        end
      for (int k = 0; k < len; k++) begin
        v = int'($urandom_range(0, 65535)) - 32768;
        ain_buf[k] = v[15:0];
      end
      run_pass(len, acc, 2, $urandom_range(0, 4), 0);
      total_cnt++;
      if (r_to || r_lat != 4 || !r_stable || !r_drop_ok)
        $display("FAIL rand%0d_timing: got lat=%0d to=%0d stable=%0d drop=%0d want 4/0/1/1", it, r_lat, r_to, r_stable, r_drop_ok);
      else pass_cnt++;
      for (int l = 0; l < 4; l++) begin
        e1 = exp_out(acc_m[l], 0, 32, s1);
        e2 = exp_out(acc_m[l], 8, 16, s2);
        total_cnt++;
        if (longint'($signed(r_dout[l*32 +: 32])) !== e1 || r_sat[l] !== s1 ||
            longint'($signed(r_dout2[l*16 +: 16])) !== e2 || r_sat2[l] !== s2)
          $display("FAIL rand%0d_lane%0d: got %0d/%b %0d/%b want %0d/%b %0d/%b", it, l,
                   $signed(r_dout[l*32 +: 32]), r_sat[l], $signed(r_dout2[l*16 +: 16]), r_sat2[l], e1, s1, e2, s2);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_accum;
    test_reject;
    test_midpass_reset;
    test_round_sat;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
